// File: rtl/tlc_pkg.sv
// tlc_pkg: pedestrian FSM encoding and counter sizing
// shared by the input conditioner and the controller.
package tlc_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PENDING = 2'd1,
    FAULT   = 2'd2
  } ped_state_e;

  // Bits needed to hold 0..max_val; never narrower than 1.
  function automatic int cnt_width(input int max_val);
    if (max_val < 1) return 1;
    return $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/tlc_input_conditioner_if.sv
// tlc_input_conditioner_if: raw inputs and conditioned
// demand outputs between the board and the controller.
interface tlc_input_conditioner_if;

  logic pedestrian_button;
  logic traffic_sensor;
  logic ped_ack;
  logic ped_request;
  logic ped_press_pulse;
  logic traffic_present;
  logic ped_fault;

  modport master (
    output pedestrian_button,
    output traffic_sensor,
    output ped_ack,
    input  ped_request,
    input  ped_press_pulse,
    input  traffic_present,
    input  ped_fault
  );

  modport slave (
    input  pedestrian_button,
    input  traffic_sensor,
    input  ped_ack,
    output ped_request,
    output ped_press_pulse,
    output traffic_present,
    output ped_fault
  );

endinterface

// File: rtl/tlc_debounce.sv
// tlc_debounce: 2-flop synchroniser, saturating debounce
// counter and stable-edge strobes for one raw input.
module tlc_debounce
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic stable,
  output logic rise,
  output logic fall
);

  localparam int CW = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CW-1:0] CNT_LAST =
    CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] CNT_MAX =
    CW'(DEBOUNCE_CYCLES);

  logic          r_s1;
  logic          r_s2;
  logic          r_stable;
  logic [CW-1:0] r_cnt;
  logic          w_done;

  // Stable flips on this edge: rise/fall strobe the
  // cycle before stable shows the new level.
  assign w_done = (r_s2 != r_stable) &&
                  (r_cnt == CNT_LAST);

  // Two-flop synchroniser for the asynchronous level.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_s1 <= 1'b0;
      r_s2 <= 1'b0;
    end else begin
      r_s1 <= din;
      r_s2 <= r_s1;
    end
  end

  // Count consecutive disagreeing cycles, then accept.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stable <= 1'b0;
      r_cnt    <= '0;
    end else if (r_s2 == r_stable) begin
      r_cnt    <= '0;
    end else if (w_done) begin
      r_stable <= r_s2;
      r_cnt    <= '0;
    end else if (r_cnt != CNT_MAX) begin
      r_cnt    <= r_cnt + CW'(1);
    end
  end

  assign stable = r_stable;
  assign rise   = w_done & r_s2;
  assign fall   = w_done & ~r_s2;

endmodule

// File: rtl/tlc_input_conditioner.sv
// tlc_input_conditioner: debounced pedestrian request latch
// and hold-stretched sensor demand. TLC_STUCK_DETECT_EN adds stuck-button FAULT.
module tlc_input_conditioner
  import tlc_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES    = 4,
  parameter int SENSOR_HOLD_CYCLES = 8,
  parameter int STUCK_CYCLES       = 64
) (
  input logic                    clk,
  input logic                    reset,
  tlc_input_conditioner_if.slave bus
);

  localparam int HOLD_W = cnt_width(SENSOR_HOLD_CYCLES);

  logic w_btn_stable;
  logic w_btn_rise;
  logic w_btn_fall;
  logic w_sen_stable;
  logic w_sen_rise;
  logic w_sen_fall;
  logic w_unused;

  ped_state_e r_state;
  ped_state_e w_state_nxt;
  logic       r_press;
  logic       r_present;
  logic       w_sen_nxt;
  logic       w_stuck;

  logic [HOLD_W-1:0] r_hold;
  logic [HOLD_W-1:0] w_hold_nxt;

  tlc_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_btn_db (
    .clk   (clk),
    .reset (reset),
    .din   (bus.pedestrian_button),
    .stable(w_btn_stable),
    .rise  (w_btn_rise),
    .fall  (w_btn_fall)
  );

  tlc_debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_sen_db (
    .clk   (clk),
    .reset (reset),
    .din   (bus.traffic_sensor),
    .stable(w_sen_stable),
    .rise  (w_sen_rise),
    .fall  (w_sen_fall)
  );

  assign w_unused = w_btn_fall;

`ifdef TLC_STUCK_DETECT_EN
  localparam int STUCK_W = cnt_width(STUCK_CYCLES);
  localparam logic [STUCK_W-1:0] STUCK_MAX =
    STUCK_W'(STUCK_CYCLES);

  logic [STUCK_W-1:0] r_stuck;

  // Saturating count of cycles the button stays pressed.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_stuck <= '0;
    end else if (!w_btn_stable) begin
      r_stuck <= '0;
    end else if (r_stuck != STUCK_MAX) begin
      r_stuck <= r_stuck + STUCK_W'(1);
    end
  end

  assign w_stuck = w_btn_stable &&
                   (r_stuck == STUCK_MAX);
`else
  localparam int lp_unused_stuck = STUCK_CYCLES;

  assign w_stuck = 1'b0;
`endif

  // One-cycle accepted press, aligned with stable rise.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_press <= 1'b0;
    end else begin
      r_press <= w_btn_rise && (r_state != FAULT);
    end
  end

  // Pedestrian FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state: a press in the ack cycle wins.
  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      IDLE: begin
        if (w_stuck)      w_state_nxt = FAULT;
        else if (r_press) w_state_nxt = PENDING;
      end
      PENDING: begin
        if (w_stuck)
          w_state_nxt = FAULT;
        else if (bus.ped_ack && !r_press)
          w_state_nxt = IDLE;
      end
      FAULT: begin
        if (!w_btn_stable) w_state_nxt = IDLE;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Hold counter next value and next stable sensor level.
  always_comb begin
    w_hold_nxt = r_hold;
    if (w_sen_fall)
      w_hold_nxt = HOLD_W'(SENSOR_HOLD_CYCLES);
    else if (w_sen_rise)
      w_hold_nxt = '0;
    else if (r_hold != '0)
      w_hold_nxt = r_hold - HOLD_W'(1);
    w_sen_nxt = w_sen_rise |
                (w_sen_stable & ~w_sen_fall);
  end

  // Registered hold count and stretched demand.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_hold    <= '0;
      r_present <= 1'b0;
    end else begin
      r_hold    <= w_hold_nxt;
      r_present <= w_sen_nxt | (w_hold_nxt != '0);
    end
  end

  assign bus.ped_request     = (r_state == PENDING);
  assign bus.ped_press_pulse = r_press;
  assign bus.traffic_present = r_present;

`ifdef TLC_STUCK_DETECT_EN
  assign bus.ped_fault = (r_state == FAULT);
`else
  assign bus.ped_fault = 1'b0;
`endif

endmodule

// File: tb/tb_tlc_input_conditioner.sv
// tb_tlc_input_conditioner: directed scenarios with
// hand-computed cycle-exact expectations.
module tb_tlc_input_conditioner;

`ifdef TLC_STUCK_DETECT_EN
  localparam bit STK = 1'b1;
`else
  localparam bit STK = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   total = 0;
  int   bad = 0;
  logic [3:0] outs;

  tlc_input_conditioner_if bus ();

  tlc_input_conditioner #(
    .DEBOUNCE_CYCLES   (4),
    .SENSOR_HOLD_CYCLES(8),
    .STUCK_CYCLES      (64)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  always #5 clk = ~clk;

  assign outs = {bus.ped_request, bus.ped_press_pulse,
                 bus.traffic_present, bus.ped_fault};

  task automatic tick(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      bus.pedestrian_button = ~bus.pedestrian_button;
      bus.traffic_sensor = ~bus.traffic_sensor;
      tick(1);
      total++;
      if (outs !== 4'b0000) begin
        bad++;
        $display("FAIL reset_hold cyc=%0d got=%b want=0000",
                 i, outs);
      end
    end
    bus.pedestrian_button = 1'b0;
    bus.traffic_sensor = 1'b0;
    reset = 1'b0;
    tick(10);
    total++;
    if (outs !== 4'b0000) begin
      bad++;
      $display("FAIL reset_release got=%b want=0000", outs);
    end
  endtask

  task automatic test_glitch();
    bus.pedestrian_button = 1'b1;
    tick(2);
    bus.pedestrian_button = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick(1);
      total++;
      if ({bus.ped_press_pulse, bus.ped_request} !== 2'b00)
      begin
        bad++;
        $display("FAIL glitch cyc=%0d got=%b%b want=00", c,
                 bus.ped_press_pulse, bus.ped_request);
      end
    end
  endtask

  task automatic test_press_ack();
    logic ep;
    bus.pedestrian_button = 1'b1;
    for (int c = 1; c <= 8; c++) begin
      tick(1);
      ep = (c == 6);
      total++;
      if (bus.ped_press_pulse !== ep) begin
        bad++;
        $display("FAIL press_pulse cyc=%0d got=%b want=%b",
                 c, bus.ped_press_pulse, ep);
      end
      total++;
      if (bus.ped_request !== (c >= 7)) begin
        bad++;
        $display("FAIL press_req cyc=%0d got=%b want=%b",
                 c, bus.ped_request, (c >= 7));
      end
    end
    bus.pedestrian_button = 1'b0;
    tick(12);
    total++;
    if (bus.ped_request !== 1'b1) begin
      bad++;
      $display("FAIL req_held got=%b want=1",
               bus.ped_request);
    end
    bus.ped_ack = 1'b1;
    tick(1);
    bus.ped_ack = 1'b0;
    total++;
    if (bus.ped_request !== 1'b0) begin
      bad++;
      $display("FAIL ack_clear got=%b want=0",
               bus.ped_request);
    end
    tick(5);
    bus.ped_ack = 1'b1;
    tick(1);
    bus.ped_ack = 1'b0;
    tick(1);
    total++;
    if ({bus.ped_request, bus.ped_press_pulse} !== 2'b00)
    begin
      bad++;
      $display("FAIL idle_ack got=%b%b want=00",
               bus.ped_request, bus.ped_press_pulse);
    end
  endtask

  task automatic test_sensor();
    bus.traffic_sensor = 1'b1;
    for (int c = 1; c <= 10; c++) begin
      tick(1);
      total++;
      if (bus.traffic_present !== (c >= 6)) begin
        bad++;
        $display("FAIL sen_rise cyc=%0d got=%b want=%b",
                 c, bus.traffic_present, (c >= 6));
      end
    end
    bus.traffic_sensor = 1'b0;
    for (int c = 1; c <= 16; c++) begin
      tick(1);
      total++;
      if (bus.traffic_present !== (c < 14)) begin
        bad++;
        $display("FAIL sen_fall cyc=%0d got=%b want=%b",
                 c, bus.traffic_present, (c < 14));
      end
    end
    bus.traffic_sensor = 1'b1;
    tick(10);
    bus.traffic_sensor = 1'b0;
    tick(3);
    bus.traffic_sensor = 1'b1;
    for (int c = 1; c <= 12; c++) begin
      tick(1);
      total++;
      if (bus.traffic_present !== 1'b1) begin
        bad++;
        $display("FAIL sen_gap cyc=%0d got=%b want=1",
                 c, bus.traffic_present);
      end
    end
    bus.traffic_sensor = 1'b0;
    for (int c = 1; c <= 20; c++) begin
      tick(1);
      if (c == 6) bus.traffic_sensor = 1'b1;
      total++;
      if (bus.traffic_present !== 1'b1) begin
        bad++;
        $display("FAIL sen_rehold cyc=%0d got=%b want=1",
                 c, bus.traffic_present);
      end
    end
    bus.traffic_sensor = 1'b0;
    tick(20);
    total++;
    if (bus.traffic_present !== 1'b0) begin
      bad++;
      $display("FAIL sen_idle got=%b want=0",
               bus.traffic_present);
    end
  endtask

  task automatic test_ack_with_press();
    bus.pedestrian_button = 1'b1;
    tick(7);
    bus.pedestrian_button = 1'b0;
    tick(12);
    bus.pedestrian_button = 1'b1;
    tick(6);
    total++;
    if ({bus.ped_press_pulse, bus.ped_request} !== 2'b11)
    begin
      bad++;
      $display("FAIL second_press got=%b%b want=11",
               bus.ped_press_pulse, bus.ped_request);
    end
    bus.ped_ack = 1'b1;
    tick(1);
    bus.ped_ack = 1'b0;
    total++;
    if (bus.ped_request !== 1'b1) begin
      bad++;
      $display("FAIL ack_press_same got=%b want=1",
               bus.ped_request);
    end
    bus.pedestrian_button = 1'b0;
    tick(12);
    total++;
    if (bus.ped_request !== 1'b1) begin
      bad++;
      $display("FAIL ack_press_kept got=%b want=1",
               bus.ped_request);
    end
    bus.ped_ack = 1'b1;
    tick(1);
    bus.ped_ack = 1'b0;
    total++;
    if (bus.ped_request !== 1'b0) begin
      bad++;
      $display("FAIL lone_ack got=%b want=0",
               bus.ped_request);
    end
  endtask

  task automatic test_reset_mid();
    bus.pedestrian_button = 1'b1;
    bus.traffic_sensor = 1'b1;
    tick(8);
    total++;
    if (outs !== 4'b1010) begin
      bad++;
      $display("FAIL pre_reset got=%b want=1010", outs);
    end
    #2 reset = 1'b1;
    #1;
    total++;
    if (outs !== 4'b0000) begin
      bad++;
      $display("FAIL async_reset got=%b want=0000", outs);
    end
    bus.pedestrian_button = 1'b0;
    bus.traffic_sensor = 1'b0;
    tick(3);
    reset = 1'b0;
    tick(12);
    total++;
    if (outs !== 4'b0000) begin
      bad++;
      $display("FAIL post_reset got=%b want=0000", outs);
    end
  endtask

  task automatic test_stuck();
    logic ef;
    logic er;
    bus.pedestrian_button = 1'b1;
    for (int c = 1; c <= 80; c++) begin
      tick(1);
      ef = STK && (c >= 71);
      er = (c >= 7) && !(STK && (c >= 71));
      total++;
      if ({bus.ped_fault, bus.ped_request} !== {ef, er})
      begin
        bad++;
        $display("FAIL stuck_hold cyc=%0d got=%b%b want=%b%b",
                 c, bus.ped_fault, bus.ped_request, ef, er);
      end
    end
    bus.pedestrian_button = 1'b0;
    for (int c = 1; c <= 10; c++) begin
      tick(1);
      ef = STK && (c < 7);
      er = !STK;
      total++;
      if ({bus.ped_fault, bus.ped_request} !== {ef, er})
      begin
        bad++;
        $display("FAIL stuck_rel cyc=%0d got=%b%b want=%b%b",
                 c, bus.ped_fault, bus.ped_request, ef, er);
      end
    end
    bus.ped_ack = 1'b1;
    tick(1);
    bus.ped_ack = 1'b0;
    bus.pedestrian_button = 1'b1;
    tick(6);
    total++;
    if (bus.ped_press_pulse !== 1'b1) begin
      bad++;
      $display("FAIL clean_pulse got=%b want=1",
               bus.ped_press_pulse);
    end
    tick(1);
    total++;
    if ({bus.ped_fault, bus.ped_request} !== 2'b01) begin
      bad++;
      $display("FAIL clean_req got=%b%b want=01",
               bus.ped_fault, bus.ped_request);
    end
    bus.pedestrian_button = 1'b0;
    tick(10);
    bus.ped_ack = 1'b1;
    tick(1);
    bus.ped_ack = 1'b0;
    total++;
    if (bus.ped_request !== 1'b0) begin
      bad++;
      $display("FAIL final_ack got=%b want=0",
               bus.ped_request);
    end
  endtask

  initial begin
    reset = 1'b1;
    bus.pedestrian_button = 1'b0;
    bus.traffic_sensor = 1'b0;
    bus.ped_ack = 1'b0;
    tick(1);
    test_reset();
    test_glitch();
    test_press_ack();
    test_sensor();
    test_ack_with_press();
    test_reset_mid();
    test_stuck();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
